// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster generator.
// Defaults describe 640x480@59.94 Hz from a 100.7 MHz master clock.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CE_DIV   = 4;

   localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int HS_END   = HS_START + DEF_H_SYNC;
   localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int VS_END   = VS_START + DEF_V_SYNC;

   // Both totals (800, 525) need 10 bits, so one position type covers x and y.
   localparam int POS_W = $clog2(H_TOTAL);

   typedef logic [POS_W-1:0] pos_t;

   // Half-open window test used for the sync pulses.
   function automatic logic in_window(input pos_t p, input pos_t lo, input pos_t hi);
      return (p >= lo) && (p < hi);
   endfunction

endpackage

// File: rtl/ce_prescaler.sv
// Divides the master clock down to a one-in-CE_DIV pixel enable.
// tick is the combinational "pre is at its last count" term the raster logic advances on.
module ce_prescaler #(
   parameter int CE_DIV = 4
) (
   input  logic CLKIN_100700kHz,
   input  logic rst_n,
   input  logic run,
   output logic tick,
   output logic pix_ce
);

   localparam int PRE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [PRE_W-1:0] LAST = PRE_W'(CE_DIV - 1);

   logic [PRE_W-1:0] pre;

   assign tick = run && (pre == LAST);

   always_ff @(posedge CLKIN_100700kHz or negedge rst_n) begin
      if (!rst_n) begin
         pre    <= '0;
         pix_ce <= 1'b0;
      end else if (!run) begin
         pre    <= '0;
         pix_ce <= 1'b0;
      end else begin
         pix_ce <= (pre == LAST);
         pre    <= (pre == LAST) ? '0 : pre + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, h/v counters and registered sync/de/strobe decode.
// All state clears synchronously whenever clks_valid & en drops.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CE_DIV   = DEF_CE_DIV
) (
   input  logic                  CLKIN_100700kHz,
   input  logic                  rst_n,
   input  logic                  clks_valid,
   input  logic                  en,
   output logic                  pix_ce,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  de,
   output logic [POS_W-1:0]      x,
   output logic [POS_W-1:0]      y,
   output logic                  line_start,
   output logic                  frame_start
);

   localparam int   H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam pos_t H_LAST   = pos_t'(H_TOT - 1);
   localparam pos_t V_LAST   = pos_t'(V_TOT - 1);
   localparam pos_t H_ACT    = pos_t'(H_ACTIVE);
   localparam pos_t V_ACT    = pos_t'(V_ACTIVE);
   localparam pos_t HS_BEGIN = pos_t'(H_ACTIVE + H_FP);
   localparam pos_t HS_STOP  = pos_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam pos_t VS_BEGIN = pos_t'(V_ACTIVE + V_FP);
   localparam pos_t VS_STOP  = pos_t'(V_ACTIVE + V_FP + V_SYNC);

   logic run;
   logic tick;
   logic primed;
   pos_t h_cnt;
   pos_t v_cnt;
   pos_t h_next;
   pos_t v_next;

   assign run = clks_valid & en;
   assign x   = h_cnt;
   assign y   = v_cnt;

   ce_prescaler #(
      .CE_DIV (CE_DIV)
   ) u_ce_prescaler (
      .CLKIN_100700kHz (CLKIN_100700kHz),
      .rst_n           (rst_n),
      .run             (run),
      .tick            (tick),
      .pix_ce          (pix_ce)
   );

   // The first tick after run rises only arms the counters, so the raster
   // starts at (0,0) together with the very first pix_ce.
   always_comb begin
      h_next = h_cnt;
      v_next = v_cnt;
      if (primed) begin
         if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_next = h_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLKIN_100700kHz or negedge rst_n) begin
      if (!rst_n) begin
         primed      <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (!run) begin
         primed      <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (tick) begin
            primed      <= 1'b1;
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            de          <= (h_next < H_ACT) && (v_next < V_ACT);
            hsync       <= in_window(h_next, HS_BEGIN, HS_STOP) ? HS_POL : ~HS_POL;
            vsync       <= in_window(v_next, VS_BEGIN, VS_STOP) ? VS_POL : ~VS_POL;
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one full-size instance for line timing, one
// reduced-raster instance (32x15) so whole frames fit in a short run.
module tb_vga_timing_gen;

   localparam logic [25:0] RST_B   = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
   localparam logic [25:0] FIRST_B = {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1};

   logic clk = 1'b0;
   logic rst_n;
   logic clks_valid;
   logic en;

   logic       v_pix_ce, v_hsync, v_vsync, v_de, v_line_start, v_frame_start;
   logic [9:0] v_x, v_y;
   logic       s_pix_ce, s_hsync, s_vsync, s_de, s_line_start, s_frame_start;
   logic [9:0] s_x, s_y;
   logic [25:0] got_v, got_s;

   int checks = 0;
   int errors = 0;
   int m = 0;  // posedges seen with run high since it last rose
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   assign got_v = {v_pix_ce, v_hsync, v_vsync, v_de, v_x, v_y, v_line_start, v_frame_start};
   assign got_s = {s_pix_ce, s_hsync, s_vsync, s_de, s_x, s_y, s_line_start, s_frame_start};

   vga_timing_gen dut_v (
      .CLKIN_100700kHz (clk),
      .rst_n           (rst_n),
      .clks_valid      (clks_valid),
      .en              (en),
      .pix_ce          (v_pix_ce),
      .hsync           (v_hsync),
      .vsync           (v_vsync),
      .de              (v_de),
      .x               (v_x),
      .y               (v_y),
      .line_start      (v_line_start),
      .frame_start     (v_frame_start)
   );

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
      .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3)
   ) dut_s (
      .CLKIN_100700kHz (clk),
      .rst_n           (rst_n),
      .clks_valid      (clks_valid),
      .en              (en),
      .pix_ce          (s_pix_ce),
      .hsync           (s_hsync),
      .vsync           (s_vsync),
      .de              (s_de),
      .x               (s_x),
      .y               (s_y),
      .line_start      (s_line_start),
      .frame_start     (s_frame_start)
   );

   // Closed-form expectation after m run cycles: tick k (k>=1) lands on cycle 4k
   // and shows raster position k-1.
   function automatic logic [25:0] model(input int mc, input int ha, input int hfp,
                                         input int hsw, input int hbp, input int va,
                                         input int vfp, input int vsw, input int vbp);
      int ht, vt, p, h, v;
      logic ce, hs, vs, d, ls;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      if (mc < 4) return RST_B;
      p  = mc / 4 - 1;
      h  = p % ht;
      v  = (p / ht) % vt;
      ce = (mc % 4 == 0);
      hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
      vs = !((v >= va + vfp) && (v < va + vfp + vsw));
      d  = (h < ha) && (v < va);
      ls = ce && (h == 0);
      return {ce, hs, vs, d, 10'(h), 10'(v), ls, ls && (v == 0)};
   endfunction

   function automatic logic [25:0] model_v(input int mc);
      return model(mc, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction

   function automatic logic [25:0] model_s(input int mc);
      return model(mc, 16, 4, 6, 6, 8, 2, 2, 3);
   endfunction

   task automatic step();
      @(posedge clk);
      m = (rst_n && clks_valid && en) ? m + 1 : 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clks_valid = 1'b0; en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (got_v !== RST_B) begin errors++; $display("FAIL reset_v got=%h exp=%h", got_v, RST_B); end
      checks++;
      if (got_s !== RST_B) begin errors++; $display("FAIL reset_s got=%h exp=%h", got_s, RST_B); end
      rst_n = 1'b1; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (got_s !== RST_B || got_v !== RST_B) begin
            errors++;
            $display("FAIL idle_no_clks got_s=%h got_v=%h exp=%h", got_s, got_v, RST_B);
            break;
         end
      end
   endtask

   task automatic test_first_ce();
      clks_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (s_pix_ce !== 1'b0 || v_pix_ce !== 1'b0) begin
            errors++; $display("FAIL early_pix_ce cycle=%0d got=%b/%b exp=0", i, s_pix_ce, v_pix_ce);
         end
      end
      step();
      checks++;
      if (got_v !== FIRST_B) begin errors++; $display("FAIL first_ce_v got=%h exp=%h", got_v, FIRST_B); end
      checks++;
      if (got_s !== FIRST_B) begin errors++; $display("FAIL first_ce_s got=%h exp=%h", got_s, FIRST_B); end
      step();
      checks++;
      if (got_s !== {1'b0, 1'b1, 1'b1, 1'b1, 20'd0, 2'b00}) begin
         errors++; $display("FAIL strobe_drop got=%h exp=%h", got_s, {1'b0, 1'b1, 1'b1, 1'b1, 20'd0, 2'b00});
      end
   endtask

   task automatic test_line_default();
      int hs_low = 0, de_ce = 0, ls_cnt = 0;
      logic ls_end = 1'b0;
      while (m < 3208) begin
         step();
         checks++;
         if (got_v !== model_v(m)) begin
            errors++; $display("FAIL line_lockstep_v m=%0d got=%h exp=%h", m, got_v, model_v(m)); break;
         end
         if (m >= 5 && m <= 3204) begin
            if (!v_hsync) hs_low++;
            if (v_pix_ce && v_de) de_ce++;
            if (v_line_start) ls_cnt++;
         end
         if (m == 3204) ls_end = v_line_start;
      end
      checks++;
      if (hs_low !== 384) begin errors++; $display("FAIL hsync_low_cycles got=%0d exp=384", hs_low); end
      checks++;
      if (de_ce !== 640) begin errors++; $display("FAIL de_pixels got=%0d exp=640", de_ce); end
      checks++;
      if (ls_cnt !== 1) begin errors++; $display("FAIL line_starts_per_line got=%0d exp=1", ls_cnt); end
      checks++;
      if (ls_end !== 1'b1) begin errors++; $display("FAIL line_period_3200 got=%b exp=1", ls_end); end
   endtask

   task automatic test_frame_small();
      int vs_low = 0, fs_cnt = 0, de_bad = 0;
      logic [9:0] want;
      for (int i = 0; i < 15; i++) exp_q.push_back(10'(i));
      exp_q.push_back(10'd0);
      while (m < 5768) begin
         step();
         checks++;
         if (got_s !== model_s(m)) begin
            errors++; $display("FAIL frame_lockstep_s m=%0d got=%h exp=%h", m, got_s, model_s(m)); break;
         end
         if (s_de && s_y >= 10'd8) de_bad++;
         if (m >= 3844 && m <= 5764) begin
            if (m <= 5763 && !s_vsync) vs_low++;
            if (s_frame_start) fs_cnt++;
            if (s_line_start) begin
               want = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
               checks++;
               if (s_y !== want) begin errors++; $display("FAIL line_y m=%0d got=%0d exp=%0d", m, s_y, want); end
            end
         end
      end
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL lines_per_frame left=%0d exp=0", exp_q.size()); end
      checks++;
      if (vs_low !== 256) begin errors++; $display("FAIL vsync_low_cycles got=%0d exp=256", vs_low); end
      checks++;
      if (fs_cnt !== 2) begin errors++; $display("FAIL frame_period_1920 got=%0d exp=2", fs_cnt); end
      checks++;
      if (de_bad !== 0) begin errors++; $display("FAIL de_in_vblank got=%0d exp=0", de_bad); end
   endtask

   task automatic test_en_drop();
      while (m < 6486) begin
         step();
         checks++;
         if (got_s !== model_s(m)) begin
            errors++; $display("FAIL pre_drop_s m=%0d got=%h exp=%h", m, got_s, model_s(m)); break;
         end
      end
      checks++;
      if ({s_x, s_y} !== {10'd20, 10'd5}) begin
         errors++; $display("FAIL drop_position got=%0d,%0d exp=20,5", s_x, s_y);
      end
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (got_s !== RST_B || got_v !== RST_B) begin
            errors++; $display("FAIL en_low_reset i=%0d got_s=%h got_v=%h exp=%h", i, got_s, got_v, RST_B); break;
         end
      end
      en = 1'b1;
      while (m < 140) begin
         step();
         checks++;
         if (got_s !== model_s(m) || got_v !== model_v(m)) begin
            errors++; $display("FAIL en_restart m=%0d got_s=%h exp_s=%h", m, got_s, model_s(m)); break;
         end
      end
   endtask

   task automatic test_clks_valid_drop();
      while (m < 200) step();
      clks_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (got_s !== RST_B || s_pix_ce !== 1'b0) begin
            errors++; $display("FAIL clks_low_reset i=%0d got=%h exp=%h", i, got_s, RST_B); break;
         end
      end
      clks_valid = 1'b1;
      repeat (4) step();
      checks++;
      if (got_s !== FIRST_B) begin errors++; $display("FAIL clks_restart got=%h exp=%h", got_s, FIRST_B); end
   endtask

   task automatic test_async_reset();
      while (m < 300) step();
      @(posedge clk);
      #3 rst_n = 1'b0;
      m = 0;
      #1;
      checks++;
      if (got_s !== RST_B || got_v !== RST_B) begin
         errors++; $display("FAIL async_reset got_s=%h got_v=%h exp=%h", got_s, got_v, RST_B);
      end
      @(negedge clk);
      step();
      rst_n = 1'b1;
      while (m < 40) begin
         step();
         checks++;
         if (got_s !== model_s(m) || got_v !== model_v(m)) begin
            errors++; $display("FAIL post_reset m=%0d got_s=%h exp_s=%h", m, got_s, model_s(m)); break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_ce();
      test_line_default();
      test_frame_small();
      test_en_drop();
      test_clks_valid_drop();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
